// File: rtl/capture_buffer_master.sv
`timescale 1ns/1ps
// capture_buffer_master
//   Initiator for the capture buffer's write/read port. After a start pulse it
//   pulls buffer_length I/Q samples from an upstream valid/ready stream and
//   writes them to buffer addresses 0..buffer_length-1. It then reads the same
//   addresses back in order and hands each sample downstream on a valid/ready
//   stream. A missing write response or read data beat aborts the run with a
//   sticky error flag.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start/busy/done/error run control: start pulse, run-in-progress,
//                         end-of-run pulse, sticky timeout flag
//   in_valid/in_ready     upstream sample handshake, sample on in_i/in_q
//   m_axi_waddr/wvalid/wdata, s_axi_wready
//                         write request channel, wdata = {I, Q}
//   s_axi_bvalid/bresp, m_axi_bready
//                         write response channel (bresp unused)
//   m_axi_raddr/rvalid    read request (single-cycle pulse)
//   s_axi_rvalid, i, q, m_axi_rready, s_axi_rready
//                         read data return (s_axi_rready unused)
//   out_valid/out_ready   downstream sample handshake, sample on out_i/out_q
module capture_buffer_master #(
  parameter int buffer_length  = 10,
  parameter int index_bits     = 4,
  parameter int i_bits         = 12,
  parameter int q_bits         = 12,
  parameter int timeout_cycles = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [i_bits-1:0]        in_i,
  input  logic [q_bits-1:0]        in_q,
  output logic [index_bits-1:0]    m_axi_waddr,
  output logic                     m_axi_wvalid,
  output logic [i_bits+q_bits-1:0] m_axi_wdata,
  input  logic                     s_axi_wready,
  input  logic                     s_axi_bvalid,
  input  logic                     s_axi_bresp,
  output logic                     m_axi_bready,
  output logic [index_bits-1:0]    m_axi_raddr,
  output logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic                     s_axi_rready,
  input  logic                     s_axi_rvalid,
  input  logic [i_bits-1:0]        i,
  input  logic [q_bits-1:0]        q,
  output logic                     out_valid,
  output logic [i_bits-1:0]        out_i,
  output logic [q_bits-1:0]        out_q,
  input  logic                     out_ready
);

  localparam int TMR_W = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_IN,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_OUT
  } state_t;

  state_t                  state, state_nxt;
  logic [index_bits-1:0]   addr, addr_nxt;
  logic [TMR_W-1:0]        timer, timer_nxt;
  logic                    error_q, error_nxt;
  logic                    done_q, done_nxt;
  logic                    wr_load, rd_load;
  logic                    last_addr, timer_expired;

  logic signed [i_bits-1:0] wr_i_p0, rd_i_p1;
  logic signed [q_bits-1:0] wr_q_p0, rd_q_p1;

  // Response fields this initiator has no use for.
  logic unused_inputs;
  assign unused_inputs = s_axi_bresp ^ s_axi_rready;

  assign last_addr     = (addr == index_bits'(buffer_length - 1));
  // The wait that lands on this count is the timeout_cycles-th waiting cycle.
  assign timer_expired = (timer == TMR_W'(timeout_cycles - 1));

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    timer_nxt    = timer;
    error_nxt    = error_q;
    done_nxt     = 1'b0;
    wr_load      = 1'b0;
    rd_load      = 1'b0;
    in_ready     = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rready = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE: begin
        // done_q high means this is the cycle right after a finished run;
        // a start arriving then is dropped.
        if (start && !done_q) begin
          state_nxt = WR_IN;
          addr_nxt  = '0;
          error_nxt = 1'b0;
        end
      end
      WR_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_load   = 1'b1;
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        m_axi_wvalid = 1'b1;
        if (s_axi_wready) begin
          state_nxt = WR_RESP;
          timer_nxt = '0;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (s_axi_bvalid) begin
          if (last_addr) begin
            addr_nxt  = '0;
            state_nxt = RD_REQ;
          end else begin
            addr_nxt  = addr + index_bits'(1);
            state_nxt = WR_IN;
          end
        end else if (timer_expired) begin
          error_nxt = 1'b1;
          addr_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      RD_REQ: begin
        m_axi_rvalid = 1'b1;
        timer_nxt    = '0;
        state_nxt    = RD_WAIT;
      end
      RD_WAIT: begin
        m_axi_rready = 1'b1;
        if (s_axi_rvalid) begin
          rd_load   = 1'b1;
          state_nxt = RD_OUT;
        end else if (timer_expired) begin
          error_nxt = 1'b1;
          addr_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_addr) begin
            done_nxt  = 1'b1;
            addr_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            addr_nxt  = addr + index_bits'(1);
            state_nxt = RD_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      timer   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      timer   <= timer_nxt;
      error_q <= error_nxt;
      done_q  <= done_nxt;
    end
  end

  // Stage p0: upstream sample captured for the write request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_i_p0 <= '0;
      wr_q_p0 <= '0;
    end else if (wr_load) begin
      wr_i_p0 <= in_i;
      wr_q_p0 <= in_q;
    end
  end

  // Stage p1: read-back sample captured and held until downstream accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_i_p1 <= '0;
      rd_q_p1 <= '0;
    end else if (rd_load) begin
      rd_i_p1 <= i;
      rd_q_p1 <= q;
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign m_axi_waddr = addr;
  assign m_axi_raddr = addr;
  assign m_axi_wdata = {wr_i_p0, wr_q_p0};
  assign out_i       = rd_i_p1;
  assign out_q       = rd_q_p1;

endmodule

// File: tb/tb_capture_buffer_master.sv
`timescale 1ns/1ps
module tb_capture_buffer_master;
  localparam int LEN = 10;
  localparam int IB  = 4;
  localparam int IW  = 12;
  localparam int QW  = 12;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_i = '0;
  logic [QW-1:0] in_q = '0;
  logic [IB-1:0] m_axi_waddr;
  logic          m_axi_wvalid;
  logic [IW+QW-1:0] m_axi_wdata;
  logic          s_axi_wready = 1'b0;
  logic          s_axi_bvalid = 1'b0;
  logic          s_axi_bresp = 1'b0;
  logic          m_axi_bready;
  logic [IB-1:0] m_axi_raddr;
  logic          m_axi_rvalid, m_axi_rready;
  logic          s_axi_rready = 1'b1;
  logic          s_axi_rvalid = 1'b0;
  logic [IW-1:0] i = '0;
  logic [QW-1:0] q = '0;
  logic          out_valid;
  logic [IW-1:0] out_i;
  logic [QW-1:0] out_q;
  logic          out_ready = 1'b1;

  capture_buffer_master #(
    .buffer_length(LEN), .index_bits(IB), .i_bits(IW), .q_bits(QW), .timeout_cycles(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .m_axi_waddr(m_axi_waddr), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp),
    .m_axi_bready(m_axi_bready), .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid),
    .i(i), .q(q), .out_valid(out_valid), .out_i(out_i), .out_q(out_q), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scenario knobs, written only by the stimulus process.
  int cfg_gap      = 0;
  int cfg_wst_addr = 15;
  int cfg_wst      = 0;
  int cfg_hold_addr = 15;
  int cfg_hold     = 0;
  bit cfg_no_bresp = 1'b0;

  // Upstream source: sample k is I=k, Q=-k; restarts at k=0 on each start.
  int src_k = LEN;
  int gcnt  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      src_k = LEN; gcnt = 0; in_valid = 1'b0;
    end else begin
      if (start && !busy) begin src_k = 0; gcnt = 0; end
      if (gcnt > 0) begin
        in_valid = 1'b0;
        gcnt--;
      end else if (src_k < LEN) begin
        in_valid = 1'b1;
        in_i = IW'(src_k);
        in_q = QW'(-src_k);
        if (in_ready) src_k++;
        gcnt = cfg_gap;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Capture buffer responder and downstream sink.
  logic [IW+QW-1:0] mem [16];
  logic [IB-1:0]    wr_log [$];
  logic [IB-1:0]    rd_addr = '0;
  bit               b_pend = 1'b0;
  int               wst_cnt = 0, hold_cnt = 0, rd_cnt = 0, n_reads = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_axi_wready = 1'b0; s_axi_bvalid = 1'b0; s_axi_rvalid = 1'b0;
      b_pend = 1'b0; rd_cnt = 0; wst_cnt = 0; hold_cnt = 0; out_ready = 1'b1;
    end else begin
      if (start && !busy) begin wr_log.delete(); n_reads = 0; end
      s_axi_bvalid = b_pend && !cfg_no_bresp;
      b_pend = 1'b0;
      s_axi_wready = 1'b0;
      if (m_axi_wvalid) begin
        if (int'(m_axi_waddr) == cfg_wst_addr && wst_cnt < cfg_wst) begin
          wst_cnt++;
        end else begin
          s_axi_wready = 1'b1;
          wst_cnt = 0;
          mem[m_axi_waddr] = m_axi_wdata;
          wr_log.push_back(m_axi_waddr);
          b_pend = 1'b1;
        end
      end
      s_axi_rvalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          s_axi_rvalid = 1'b1;
          i = mem[rd_addr][IW+QW-1:QW];
          q = mem[rd_addr][QW-1:0];
        end
      end
      if (m_axi_rvalid) begin
        rd_addr = m_axi_raddr; rd_cnt = 2; n_reads++; hold_cnt = 0;
      end
      out_ready = 1'b1;
      if (out_valid && int'(m_axi_raddr) == cfg_hold_addr && hold_cnt < cfg_hold) begin
        out_ready = 1'b0;
        hold_cnt++;
      end
    end
  end

  // Monitor: pops the expected sample whenever a downstream handshake occurs.
  logic [IW+QW-1:0] exp_q [$];
  logic [IW+QW-1:0] mon_exp = '0;
  logic [IW+QW-1:0] held = '0;
  bit               hold_chk = 1'b0;
  int               done_cnt = 0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (hold_chk) check("out_hold", {out_valid, out_i, out_q}, {1'b1, held});
      hold_chk = 1'b0;
      if (out_valid) begin
        if (!out_ready) begin
          hold_chk = 1'b1;
          held = {out_i, out_q};
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_extra: got 0x%0h expected no sample", {out_i, out_q});
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_sample", {out_i, out_q}, mon_exp);
        end
      end
      if (done) done_cnt++;
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic push_expected();
    for (int k = 0; k < LEN; k++) exp_q.push_back({IW'(k), QW'(-k)});
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctrl"}, {busy, done, error, in_ready, m_axi_wvalid, m_axi_bready,
                           m_axi_rvalid, m_axi_rready, out_valid}, 0);
    check({tag, "_addr"}, {m_axi_waddr, m_axi_raddr}, 0);
    check({tag, "_wdata"}, m_axi_wdata, 0);
    check({tag, "_out"}, {out_i, out_q}, 0);
  endtask

  task automatic run_case(input string tag, input int gap, input int wst_addr, input int wst,
                          input int hold_addr, input int hold);
    int  d0;
    bit  ok;
    cfg_gap = gap; cfg_wst_addr = wst_addr; cfg_wst = wst;
    cfg_hold_addr = hold_addr; cfg_hold = hold;
    push_expected();
    d0 = done_cnt;
    pulse_start();
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_error_clr"}, error, 0);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    check({tag, "_finish"}, ok, 1);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_all_out"}, exp_q.size(), 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_n_writes"}, wr_log.size(), LEN);
    for (int j = 0; j < LEN && j < wr_log.size(); j++)
      check({tag, "_waddr"}, wr_log[j], j);
    check({tag, "_n_reads"}, n_reads, LEN);
    exp_q.delete();
  endtask

  initial begin
    int  d0, cnt;
    bit  ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    #2 rst_n = 1'b1;

    run_case("base", 0, 15, 0, 15, 0);
    run_case("hold", 0, 15, 0, 3, 5);
    run_case("gap_stall", 2, 2, 4, 15, 0);

    // Write response never returned.
    cfg_gap = 0; cfg_wst = 0; cfg_hold = 0; cfg_no_bresp = 1'b1;
    d0 = done_cnt;
    pulse_start();
    cnt = 0; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (m_axi_bready) cnt++;
      if (error) begin ok = 1'b1; break; end
    end
    check("tmo_error", ok, 1);
    check("tmo_wait_cycles", cnt, TMO);
    check("tmo_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("tmo_sticky", error, 1);
    check("tmo_no_done", done_cnt - d0, 0);
    cfg_no_bresp = 1'b0;
    run_case("after_tmo", 0, 15, 0, 15, 0);

    // Reset while waiting on read data for address 6.
    push_expected();
    d0 = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (m_axi_rready && m_axi_raddr == 4'd6) begin ok = 1'b1; break; end
    end
    check("rst_reach_rd6", ok, 1);
    check("rst_out_before", {out_i, out_q}, {IW'(5), QW'(-5)});
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("midrun_rst");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle", busy, 0);
    run_case("after_rst", 0, 15, 0, 15, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
